// File: rtl/cdb_wb_arbiter.sv
// cdb_wb_arbiter
//   Arbitrates ALU / SFU / AGU results onto two registered CDB writeback ports.
//   Up to two requesters are granted every cycle. On a three-way conflict a
//   rotating pointer picks the two winners, and the loser becomes the top
//   priority for the next cycle, so no unit can starve.
// Ports
//   clk, rst_n                  clock, async active-low reset
//   flush                       kill grants and next-cycle broadcasts
//   {alu,sfu,agu}_valid/rob_num/data   unit results (held until granted)
//   {alu,sfu,agu}_ready         combinational grant
//   cdb{0,1}_valid/rob_num/data/src    registered broadcast (src 01/10/11, 00 none)
module cdb_wb_arbiter #(
    parameter int ROB_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_rob_num,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              sfu_valid,
    input  logic [ROB_W-1:0]  sfu_rob_num,
    input  logic [DATA_W-1:0] sfu_data,
    input  logic              agu_valid,
    input  logic [ROB_W-1:0]  agu_rob_num,
    input  logic [DATA_W-1:0] agu_data,
    output logic              alu_ready,
    output logic              sfu_ready,
    output logic              agu_ready,
    output logic              cdb0_valid,
    output logic [ROB_W-1:0]  cdb0_rob_num,
    output logic [DATA_W-1:0] cdb0_data,
    output logic [1:0]        cdb0_src,
    output logic              cdb1_valid,
    output logic [ROB_W-1:0]  cdb1_rob_num,
    output logic [DATA_W-1:0] cdb1_data,
    output logic [1:0]        cdb1_src
);

    // Unit indices: 0 = ALU, 1 = SFU, 2 = AGU. The CDB src code is index + 1.
    logic [1:0] ptr, p1, p2;
    logic [2:0] req, gnt;
    logic       conflict;
    logic       has0, has1;
    logic [1:0] sel0, sel1, u;
    logic [ROB_W-1:0]  rob0, rob1;
    logic [DATA_W-1:0] dat0, dat1;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] p);
        case (p)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    assign p1       = inc3(ptr);
    assign p2       = inc3(p1);
    assign req      = {agu_valid, sfu_valid, alu_valid};
    assign conflict = (&req) && !flush;

    always_comb begin
        gnt  = req;
        if (&req) gnt = req & ~onehot(p2);
        // Ready is held low during reset as well as during flush.
        if (flush || !rst_n) gnt = 3'b000;
        has0 = 1'b0;
        has1 = 1'b0;
        sel0 = 2'd0;
        sel1 = 2'd0;
        u    = 2'd0;
        // Walk grantees in priority order: first lands on cdb0, second on cdb1.
        for (int k = 0; k < 3; k++) begin
            u = (k == 0) ? ptr : (k == 1) ? p1 : p2;
            if (|(gnt & onehot(u))) begin
                if (!has0) begin
                    has0 = 1'b1;
                    sel0 = u;
                end else begin
                    has1 = 1'b1;
                    sel1 = u;
                end
            end
        end
    end

    assign alu_ready = gnt[0];
    assign sfu_ready = gnt[1];
    assign agu_ready = gnt[2];

    always_comb begin
        case (sel0)
            2'd0:    begin rob0 = alu_rob_num; dat0 = alu_data; end
            2'd1:    begin rob0 = sfu_rob_num; dat0 = sfu_data; end
            default: begin rob0 = agu_rob_num; dat0 = agu_data; end
        endcase
        case (sel1)
            2'd0:    begin rob1 = alu_rob_num; dat1 = alu_data; end
            2'd1:    begin rob1 = sfu_rob_num; dat1 = sfu_data; end
            default: begin rob1 = agu_rob_num; dat1 = agu_data; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= 2'd0;
            cdb0_valid   <= 1'b0;
            cdb0_rob_num <= '0;
            cdb0_data    <= '0;
            cdb0_src     <= 2'd0;
            cdb1_valid   <= 1'b0;
            cdb1_rob_num <= '0;
            cdb1_data    <= '0;
            cdb1_src     <= 2'd0;
        end else begin
            // Denied unit becomes top priority; flush leaves ptr alone.
            if (conflict) ptr <= p2;
            // Idle ports load zeros so stale tags never match in forwarding.
            cdb0_valid   <= has0;
            cdb0_rob_num <= has0 ? rob0 : '0;
            cdb0_data    <= has0 ? dat0 : '0;
            cdb0_src     <= has0 ? sel0 + 2'd1 : 2'd0;
            cdb1_valid   <= has1;
            cdb1_rob_num <= has1 ? rob1 : '0;
            cdb1_data    <= has1 ? dat1 : '0;
            cdb1_src     <= has1 ? sel1 + 2'd1 : 2'd0;
        end
    end

    // A waiting source must keep valid, tag and data until granted
    // (a flush releases it from that obligation).
    a_alu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (alu_valid && !alu_ready && !flush) |=>
        (alu_valid && $stable(alu_rob_num) && $stable(alu_data)));
    a_sfu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (sfu_valid && !sfu_ready && !flush) |=>
        (sfu_valid && $stable(sfu_rob_num) && $stable(sfu_data)));
    a_agu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (agu_valid && !agu_ready && !flush) |=>
        (agu_valid && $stable(agu_rob_num) && $stable(agu_data)));

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed bench for cdb_wb_arbiter: reset, single/dual grants, three-way
// rotation, flush, back-pressure stability and async reset mid-broadcast.
module tb_cdb_wb_arbiter;
    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    logic              clk, rst_n, flush;
    logic              alu_valid, sfu_valid, agu_valid;
    logic [ROB_W-1:0]  alu_rob_num, sfu_rob_num, agu_rob_num;
    logic [DATA_W-1:0] alu_data, sfu_data, agu_data;
    logic              alu_ready, sfu_ready, agu_ready;
    logic              cdb0_valid, cdb1_valid;
    logic [ROB_W-1:0]  cdb0_rob_num, cdb1_rob_num;
    logic [DATA_W-1:0] cdb0_data, cdb1_data;
    logic [1:0]        cdb0_src, cdb1_src;

    int total = 0;
    int bad   = 0;
    int n_alu, n_sfu, n_agu;

    cdb_wb_arbiter #(.ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alu_valid(alu_valid), .alu_rob_num(alu_rob_num), .alu_data(alu_data),
        .sfu_valid(sfu_valid), .sfu_rob_num(sfu_rob_num), .sfu_data(sfu_data),
        .agu_valid(agu_valid), .agu_rob_num(agu_rob_num), .agu_data(agu_data),
        .alu_ready(alu_ready), .sfu_ready(sfu_ready), .agu_ready(agu_ready),
        .cdb0_valid(cdb0_valid), .cdb0_rob_num(cdb0_rob_num),
        .cdb0_data(cdb0_data), .cdb0_src(cdb0_src),
        .cdb1_valid(cdb1_valid), .cdb1_rob_num(cdb1_rob_num),
        .cdb1_data(cdb1_data), .cdb1_src(cdb1_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Concurrent sources must never carry the same ROB tag.
    always @(posedge clk) begin
        if (rst_n) begin
            a_dup: assert (!((alu_valid && sfu_valid && alu_rob_num == sfu_rob_num) ||
                             (alu_valid && agu_valid && alu_rob_num == agu_rob_num) ||
                             (sfu_valid && agu_valid && sfu_rob_num == agu_rob_num)))
                else $error("duplicate rob tag among valid sources");
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Readys packed as {alu, sfu, agu}.
    task automatic chk_rdy(input string tag, input logic [2:0] exp);
        chk(tag, {61'd0, alu_ready, sfu_ready, agu_ready}, {61'd0, exp});
    endtask

    task automatic chk_cdb0(input string tag, input logic v, input logic [1:0] src,
                            input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] dat);
        chk({tag, "_c0v"}, cdb0_valid, v);
        chk({tag, "_c0src"}, cdb0_src, src);
        chk({tag, "_c0rob"}, cdb0_rob_num, rob);
        chk({tag, "_c0dat"}, cdb0_data, dat);
    endtask

    task automatic chk_cdb1(input string tag, input logic v, input logic [1:0] src,
                            input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] dat);
        chk({tag, "_c1v"}, cdb1_valid, v);
        chk({tag, "_c1src"}, cdb1_src, src);
        chk({tag, "_c1rob"}, cdb1_rob_num, rob);
        chk({tag, "_c1dat"}, cdb1_data, dat);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tally();
        n_alu += int'(alu_ready);
        n_sfu += int'(sfu_ready);
        n_agu += int'(agu_ready);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        alu_valid = 1'b1; alu_rob_num = 6'd0; alu_data = '0;
        sfu_valid = 1'b0; sfu_rob_num = 6'd0; sfu_data = '0;
        agu_valid = 1'b0; agu_rob_num = 6'd0; agu_data = '0;

        // Reset: ready suppressed even with a valid request
        #12;
        chk_rdy("rst_rdy", 3'b000);
        alu_valid = 1'b0;
        step();
        chk_cdb0("rst", 1'b0, 2'd0, 6'd0, 32'd0);
        chk_cdb1("rst", 1'b0, 2'd0, 6'd0, 32'd0);
        chk("rst_ptr", dut.ptr, 2'd0);
        rst_n = 1'b1;
        step();

        // Single source
        alu_valid = 1'b1; alu_rob_num = 6'd5; alu_data = 32'h1234;
        #1 chk_rdy("single_rdy", 3'b100);
        step();
        alu_valid = 1'b0;
        chk_cdb0("single", 1'b1, 2'b01, 6'd5, 32'h1234);
        chk("single_c1v", cdb1_valid, 1'b0);

        // Two sources, ptr=0: SFU outranks AGU
        sfu_valid = 1'b1; sfu_rob_num = 6'd7; sfu_data = 32'h70;
        agu_valid = 1'b1; agu_rob_num = 6'd9; agu_data = 32'h90;
        #1 chk_rdy("two_rdy", 3'b011);
        step();
        sfu_valid = 1'b0; agu_valid = 1'b0;
        chk_cdb0("two", 1'b1, 2'b10, 6'd7, 32'h70);
        chk_cdb1("two", 1'b1, 2'b11, 6'd9, 32'h90);
        chk("two_ptr", dut.ptr, 2'd0);

        // Three-way rotation
        n_alu = 0; n_sfu = 0; n_agu = 0;
        alu_valid = 1'b1; alu_rob_num = 6'd1; alu_data = 32'hA1;
        sfu_valid = 1'b1; sfu_rob_num = 6'd2; sfu_data = 32'hB2;
        agu_valid = 1'b1; agu_rob_num = 6'd3; agu_data = 32'hC3;
        #1 chk_rdy("rot1_rdy", 3'b110);
        tally();
        step();
        chk("rot1_ptr", dut.ptr, 2'd2);
        chk_cdb0("rot1", 1'b1, 2'b01, 6'd1, 32'hA1);
        chk_cdb1("rot1", 1'b1, 2'b10, 6'd2, 32'hB2);
        alu_rob_num = 6'd4; alu_data = 32'hA4;
        sfu_rob_num = 6'd5; sfu_data = 32'hB5;
        #1 chk_rdy("rot2_rdy", 3'b101);
        tally();
        step();
        chk("rot2_ptr", dut.ptr, 2'd1);
        chk_cdb0("rot2", 1'b1, 2'b11, 6'd3, 32'hC3);
        chk_cdb1("rot2", 1'b1, 2'b01, 6'd4, 32'hA4);
        agu_rob_num = 6'd6; agu_data = 32'hC6;
        alu_rob_num = 6'd7; alu_data = 32'hA7;
        #1 chk_rdy("rot3_rdy", 3'b011);
        tally();
        step();
        chk("rot3_ptr", dut.ptr, 2'd0);
        chk_cdb0("rot3", 1'b1, 2'b10, 6'd5, 32'hB5);
        chk_cdb1("rot3", 1'b1, 2'b11, 6'd6, 32'hC6);
        chk("rot_n_alu", n_alu, 2);
        chk("rot_n_sfu", n_sfu, 2);
        chk("rot_n_agu", n_agu, 2);

        // Flush with all three valid; ALU still holds tag 7
        sfu_rob_num = 6'd8;  sfu_data = 32'hB8;
        agu_rob_num = 6'd12; agu_data = 32'hDEAD;
        flush = 1'b1;
        #1 chk_rdy("flush_rdy", 3'b000);
        step();
        flush = 1'b0;
        chk_cdb0("flush", 1'b0, 2'd0, 6'd0, 32'd0);
        chk_cdb1("flush", 1'b0, 2'd0, 6'd0, 32'd0);
        chk("flush_ptr", dut.ptr, 2'd0);

        // Resume: AGU denied, must hold 12/DEAD
        #1 chk_rdy("resume_rdy", 3'b110);
        step();
        chk("resume_ptr", dut.ptr, 2'd2);
        chk_cdb0("resume", 1'b1, 2'b01, 6'd7, 32'hA7);
        chk_cdb1("resume", 1'b1, 2'b10, 6'd8, 32'hB8);

        // ptr=2 conflict: AGU then ALU, SFU denied, ptr -> 1
        alu_rob_num = 6'd10; alu_data = 32'hAA;
        sfu_rob_num = 6'd11; sfu_data = 32'hBB;
        #1 chk_rdy("edge_rdy", 3'b101);
        step();
        chk("edge_ptr", dut.ptr, 2'd1);
        chk_cdb0("bp", 1'b1, 2'b11, 6'd12, 32'hDEAD);
        chk_cdb1("edge", 1'b1, 2'b01, 6'd10, 32'hAA);

        // Async reset mid-broadcast (cdb0_valid is 1 here)
        alu_valid = 1'b0; agu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_rdy("mrst_rdy", 3'b000);
        chk_cdb0("mrst", 1'b0, 2'd0, 6'd0, 32'd0);
        chk_cdb1("mrst", 1'b0, 2'd0, 6'd0, 32'd0);
        chk("mrst_ptr", dut.ptr, 2'd0);
        sfu_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // After reset a lone AGU lands on cdb0
        agu_valid = 1'b1; agu_rob_num = 6'd20; agu_data = 32'h55;
        #1 chk_rdy("post_rdy", 3'b001);
        step();
        agu_valid = 1'b0;
        chk_cdb0("post", 1'b1, 2'b11, 6'd20, 32'h55);
        chk("post_c1v", cdb1_valid, 1'b0);
        step();
        chk("idle_c0v", cdb0_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_wb_arbiter.md
# cdb_wb_arbiter

Arbitrates completed results from the ALU, SFU and AGU onto two shared common-data-bus (CDB) writeback ports. It sits between the functional-unit outputs and the ROB/reservation-station wakeup logic. Its registered CDB outputs drive the per-unit `*_rob_num_wb` tags that dispatch-stage forwarding compares against. A rotating-priority pointer guarantees that no unit starves when all three complete together.

## Interface
- `ROB_W`, default 6: ROB tag width.
- `DATA_W`, default 32: result width.

Ports:
- `clk`, in, 1: clock; all state updates on rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `flush`, in, 1: pipeline flush; synchronous, kills pending and granted results.
- `alu_valid` / `sfu_valid` / `agu_valid`, in, 1 each: unit has a result.
- `alu_rob_num` / `sfu_rob_num` / `agu_rob_num`, in, ROB_W each: result tag.
- `alu_data` / `sfu_data` / `agu_data`, in, DATA_W each: result value.
- `alu_ready` / `sfu_ready` / `agu_ready`, out, 1 each: grant; combinational from valids, pointer and flush.
- `cdb0_valid` / `cdb1_valid`, out, 1 each: broadcast valid.
- `cdb0_rob_num` / `cdb1_rob_num`, out, ROB_W each: broadcast tag.
- `cdb0_data` / `cdb1_data`, out, DATA_W each: broadcast value.
- `cdb0_src` / `cdb1_src`, out, 2 each: source unit. 01 = ALU, 10 = SFU, 11 = AGU, 00 = none. Same encoding as the forwarding select.

## Operation
- **Handshake:** a transfer occurs when `X_valid & X_ready`. A source holds valid, tag and data stable until it is granted. Dropping valid without a grant is illegal and is checked by assertion.
- **Priority pointer:** `ptr` is a 2-bit register with values 0 = ALU, 1 = SFU, 2 = AGU; 3 is unreachable. Priority order is ptr, ptr+1, ptr+2, taken mod 3.
- **Grant rule:**
  - 0, 1 or 2 valid requesters: all are granted.
  - 3 valid requesters: the first two in priority order are granted and the third is denied.
- **Port assignment:** the higher-priority grantee goes to cdb0 and the other to cdb1. A single grantee always uses cdb0.
- **Pointer update:**
  - Only on a 3-way conflict: `ptr` is set to the denied unit, which is highest priority next cycle.
  - Otherwise `ptr` holds.
  - Flush holds `ptr`.
- **Flush:** while `flush`=1:
  - all `*_ready` are 0;
  - the next-cycle cdb0/cdb1 valid are 0;
  - tag, data and src registers load 0.
- **Invalid port:** when a port has no grantee, its valid, src, rob_num and data registers load 0.
- **Duplicate tags:** identical rob_num values on two sources are not checked in RTL; this is a bench assertion only.

## Timing
- **Reset:** during `rst_n`=0 and after release:
  - `ptr`=0;
  - cdb0/cdb1 valid = 0, src = 00, rob_num = 0, data = 0;
  - all `*_ready` = 0 while in reset.
- **Latency:** a grant in cycle N appears on the CDB registers in cycle N+1, exactly one cycle. There is no bypass from inputs to CDB outputs.
- **Throughput:** at most 2 results per cycle. A denied source is granted in the next cycle at the latest, provided flush=0.
- **Reset mid-operation:** registered CDB contents are lost immediately (async). Sources must re-present their results after reset.
- **Flush with grant:** flush and valid in the same cycle produce no transfer; the source still sees ready=0.
- **Pointer edge case:** a 3-way conflict while `ptr`=2 grants AGU then ALU and denies SFU; ptr becomes 1.

## Test plan
- **Reset:** assert rst_n=0 mid-broadcast with cdb0_valid=1 -> all CDB outputs go to 0 asynchronously, ptr=0, readys=0.
- **Single source:** alu_valid=1, rob=5, data=0x1234 -> alu_ready=1 same cycle. Next cycle cdb0_valid=1, cdb0_rob_num=5, cdb0_data=0x1234, cdb0_src=01, cdb1_valid=0.
- **Two sources:** sfu (rob 7) and agu (rob 9) valid with ptr=0 -> both ready. Next cycle cdb0 = SFU/7/src 10, cdb1 = AGU/9/src 11.
- **Three-way rotation:** all three valid for 3 consecutive cycles, each re-presenting a new tag when granted. Required results:
  - cycle 1 grants ALU+SFU, denies AGU, ptr becomes 2;
  - cycle 2 grants AGU+ALU, ptr becomes 1;
  - cycle 3 grants SFU+AGU, ptr becomes 0;
  - every unit is granted at least twice over the 3 cycles.
- **Flush:** all three valid with flush=1 -> all readys 0. Next cycle both cdb valids 0 and ptr unchanged. With flush=0 the following cycle, normal arbitration resumes.
- **Back-pressure stability:** AGU denied for one cycle keeps rob=12 and data=0xDEAD stable. It is granted next cycle and its broadcast carries exactly those values with src=11.
